// File: rtl/north_pole_pkg.sv
// Shared definitions for the machine record parser: FSM encoding, header layout, checksum width.
// MRP_CHECKSUM_EN adds the CKSUM state used by the optional per-record checksum byte.
package north_pole_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_HDR    = 4'd1,
        ST_TGT_LO = 4'd2,
        ST_TGT_HI = 4'd3,
        ST_BTN_LO = 4'd4,
        ST_BTN_HI = 4'd5,
        ST_EMIT   = 4'd6,
        ST_DONE   = 4'd7,
        ST_ERROR  = 4'd8
`ifdef MRP_CHECKSUM_EN
        , ST_CKSUM = 4'd9
`endif
    } state_e;

    localparam int HDR_BTN_MSB   = 7;
    localparam int HDR_BTN_LSB   = 4;
    localparam int HDR_LIGHT_MSB = 3;
    localparam int HDR_LIGHT_LSB = 0;
    localparam int CKSUM_W       = 8;

    function automatic logic [CKSUM_W-1:0] cksum_fold(input logic [CKSUM_W-1:0] acc,
                                                      input logic [CKSUM_W-1:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/machine_record_parser.sv
// Parses machine records from an SPI byte stream into one output beat per button.
// Optional checksum byte per record when MRP_CHECKSUM_EN is defined.
module machine_record_parser
    import north_pole_pkg::*;
#(
    parameter int MAX_LIGHT_COUNT  = 10,
    parameter int MAX_BUTTON_COUNT = 13,
    parameter int MACHINE_COUNT    = 200
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       parse_start,
    input  logic [7:0]                 rx_byte,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic                       mach_in_valid,
    input  logic                       mach_in_ready,
    output logic [MAX_LIGHT_COUNT-1:0] mach_target,
    output logic [MAX_LIGHT_COUNT-1:0] mach_button,
    output logic                       mach_buttons_end,
    output logic [15:0]                mach_index,
    output logic                       parse_done,
    output logic                       fmt_error
);

    localparam logic [4:0]  MAX_LC   = 5'(MAX_LIGHT_COUNT);
    localparam logic [3:0]  MAX_BC   = 4'(MAX_BUTTON_COUNT);
    localparam logic [15:0] LAST_IDX = 16'(MACHINE_COUNT - 1);

    state_e                     r_state;
    logic                       r_rx_ready;
    logic                       r_mach_in_valid;
    logic                       r_buttons_end;
    logic                       r_parse_done;
    logic                       r_fmt_error;
    logic [MAX_LIGHT_COUNT-1:0] r_target;
    logic [MAX_LIGHT_COUNT-1:0] r_button;
    logic [15:0]                r_mach_index;
    logic [3:0]                 r_light_cnt;
    logic [3:0]                 r_btn_cnt;
    logic [3:0]                 r_btn_idx;
    logic [7:0]                 r_lo_byte;

    logic                       w_accept;
    logic [4:0]                 w_hdr_lights;
    logic [3:0]                 w_hdr_btns;
    logic                       w_hdr_bad;
    logic                       w_last_btn;
    logic                       w_last_machine;

    assign w_accept       = rx_valid & r_rx_ready;
    assign w_hdr_lights   = {1'b0, rx_byte[HDR_LIGHT_MSB:HDR_LIGHT_LSB]};
    assign w_hdr_btns     = rx_byte[HDR_BTN_MSB:HDR_BTN_LSB];
    assign w_hdr_bad      = (w_hdr_lights == 5'd0) || (w_hdr_lights > MAX_LC) ||
                            (w_hdr_btns == 4'd0) || (w_hdr_btns > MAX_BC);
    assign w_last_btn     = (r_btn_idx == (r_btn_cnt - 4'd1));
    assign w_last_machine = (r_mach_index == LAST_IDX);

    // Lights beyond the header's count do not exist on this machine, so their bits are dropped.
    function automatic logic [MAX_LIGHT_COUNT-1:0] clip_mask(input logic [15:0] raw,
                                                             input logic [3:0]  cnt);
        logic [MAX_LIGHT_COUNT-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LIGHT_COUNT; i++) begin
            m[i] = raw[i] & (5'(i) < {1'b0, cnt});
        end
        return m;
    endfunction

`ifdef MRP_CHECKSUM_EN
    logic [CKSUM_W-1:0] r_cksum;

    // Running XOR of every record byte, seeded by the header
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cksum <= '0;
        end else if (w_accept) begin
            case (r_state)
                ST_HDR:                                     r_cksum <= rx_byte;
                ST_TGT_LO, ST_TGT_HI, ST_BTN_LO, ST_BTN_HI: r_cksum <= cksum_fold(r_cksum, rx_byte);
                default:                                    r_cksum <= r_cksum;
            endcase
        end
    end
`endif

    // Record-parsing FSM with registered handshake and data outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_rx_ready      <= 1'b0;
            r_mach_in_valid <= 1'b0;
            r_buttons_end   <= 1'b0;
            r_parse_done    <= 1'b0;
            r_fmt_error     <= 1'b0;
            r_target        <= '0;
            r_button        <= '0;
            r_mach_index    <= 16'd0;
            r_light_cnt     <= 4'd0;
            r_btn_cnt       <= 4'd0;
            r_btn_idx       <= 4'd0;
            r_lo_byte       <= 8'd0;
        end else if (parse_start) begin
            r_state         <= ST_HDR;
            r_rx_ready      <= 1'b1;
            r_mach_in_valid <= 1'b0;
            r_buttons_end   <= 1'b0;
            r_parse_done    <= 1'b0;
            r_fmt_error     <= 1'b0;
            r_mach_index    <= 16'd0;
            r_btn_idx       <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rx_ready <= 1'b0;
                end
                ST_HDR: begin
                    if (w_accept) begin
                        if (w_hdr_bad) begin
                            r_state     <= ST_ERROR;
                            r_fmt_error <= 1'b1;
                        end else begin
                            r_light_cnt <= w_hdr_lights[3:0];
                            r_btn_cnt   <= w_hdr_btns;
                            r_btn_idx   <= 4'd0;
                            r_state     <= ST_TGT_LO;
                        end
                    end
                end
                ST_TGT_LO: begin
                    if (w_accept) begin
                        r_lo_byte <= rx_byte;
                        r_state   <= ST_TGT_HI;
                    end
                end
                ST_TGT_HI: begin
                    if (w_accept) begin
                        r_target <= clip_mask({rx_byte, r_lo_byte}, r_light_cnt);
                        r_state  <= ST_BTN_LO;
                    end
                end
                ST_BTN_LO: begin
                    if (w_accept) begin
                        r_lo_byte <= rx_byte;
                        r_state   <= ST_BTN_HI;
                    end
                end
                ST_BTN_HI: begin
                    if (w_accept) begin
                        r_button        <= clip_mask({rx_byte, r_lo_byte}, r_light_cnt);
                        r_buttons_end   <= w_last_btn;
                        r_mach_in_valid <= 1'b1;
                        r_rx_ready      <= 1'b0;
                        r_state         <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (mach_in_ready) begin
                        r_mach_in_valid <= 1'b0;
                        r_buttons_end   <= 1'b0;
                        if (!r_buttons_end) begin
                            r_btn_idx  <= r_btn_idx + 4'd1;
                            r_rx_ready <= 1'b1;
                            r_state    <= ST_BTN_LO;
`ifdef MRP_CHECKSUM_EN
                        end else begin
                            r_rx_ready <= 1'b1;
                            r_state    <= ST_CKSUM;
                        end
`else
                        end else if (w_last_machine) begin
                            r_parse_done <= 1'b1;
                            r_state      <= ST_DONE;
                        end else begin
                            r_mach_index <= r_mach_index + 16'd1;
                            r_rx_ready   <= 1'b1;
                            r_state      <= ST_HDR;
                        end
`endif
                    end
                end
`ifdef MRP_CHECKSUM_EN
                ST_CKSUM: begin
                    if (w_accept) begin
                        if (rx_byte != r_cksum) begin
                            r_fmt_error <= 1'b1;
                            r_state     <= ST_ERROR;
                        end else if (w_last_machine) begin
                            r_parse_done <= 1'b1;
                            r_rx_ready   <= 1'b0;
                            r_state      <= ST_DONE;
                        end else begin
                            r_mach_index <= r_mach_index + 16'd1;
                            r_state      <= ST_HDR;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    r_rx_ready   <= 1'b0;
                    r_parse_done <= 1'b1;
                end
                ST_ERROR: begin
                    r_rx_ready      <= 1'b1;
                    r_mach_in_valid <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_rx_ready <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready         = r_rx_ready;
    assign mach_in_valid    = r_mach_in_valid;
    assign mach_target      = r_target;
    assign mach_button      = r_button;
    assign mach_buttons_end = r_buttons_end;
    assign mach_index       = r_mach_index;
    assign parse_done       = r_parse_done;
    assign fmt_error        = r_fmt_error;

endmodule

// File: tb/tb_machine_record_parser.sv
// Directed self-checking bench for machine_record_parser (MACHINE_COUNT=3).
// Sends the checksum byte of each record when MRP_CHECKSUM_EN is defined.
module tb_machine_record_parser;

    localparam int LC = 10;

    typedef struct packed {
        logic [LC-1:0] tgt;
        logic [LC-1:0] btn;
        logic          last;
        logic [15:0]   idx;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          parse_start;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ready;
    logic          mach_in_valid;
    logic          mach_in_ready;
    logic [LC-1:0] mach_target;
    logic [LC-1:0] mach_button;
    logic          mach_buttons_end;
    logic [15:0]   mach_index;
    logic          parse_done;
    logic          fmt_error;

    int    errors = 0;
    int    checks = 0;
    beat_t beats[$];
    logic [7:0] rec_q[$];
    logic [7:0] bad_hdr[$];

    always #5 clk = ~clk;

    machine_record_parser #(
        .MAX_LIGHT_COUNT (10),
        .MAX_BUTTON_COUNT(13),
        .MACHINE_COUNT   (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .parse_start     (parse_start),
        .rx_byte         (rx_byte),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .mach_in_valid   (mach_in_valid),
        .mach_in_ready   (mach_in_ready),
        .mach_target     (mach_target),
        .mach_button     (mach_button),
        .mach_buttons_end(mach_buttons_end),
        .mach_index      (mach_index),
        .parse_done      (parse_done),
        .fmt_error       (fmt_error)
    );

    // Record every beat that will transfer on the coming rising edge
    always @(negedge clk) begin
        if (mach_in_valid && mach_in_ready) beats.push_back({mach_target, mach_button, mach_buttons_end, mach_index});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) send_byte(rec_q[i]);
    endtask

    task automatic send_cksum();
`ifdef MRP_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (rec_q[i]) x = x ^ rec_q[i];
        send_byte(x);
`endif
    endtask

    task automatic wait_beats(input int n);
        int k;
        k = 0;
        while (beats.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("beat_count", 32'(beats.size()), 32'(n));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        parse_start = 1'b1;
        @(negedge clk);
        parse_start = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        parse_start   = 1'b0;
        rx_valid      = 1'b0;
        rx_byte       = 8'h00;
        mach_in_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_valid", 32'(mach_in_valid), 32'd0);
        check("rst_end", 32'(mach_buttons_end), 32'd0);
        check("rst_target", 32'(mach_target), 32'd0);
        check("rst_button", 32'(mach_button), 32'd0);
        check("rst_index", 32'(mach_index), 32'd0);
        check("rst_done", 32'(parse_done), 32'd0);
        check("rst_fmt", 32'(fmt_error), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_rx_ready", 32'(rx_ready), 32'd0);
        pulse_start();
        check("hdr_rx_ready", 32'(rx_ready), 32'd1);

        // Machine 0: 3 lights, so target bit 3 of 0x0B is dropped
        rec_q = '{8'h23, 8'h0B, 8'h00, 8'h01, 8'h00, 8'h06, 8'h00};
        send_range(0, 7);
        send_cksum();
        wait_beats(2);
        check("m0_b0_tgt", 32'(beats[0].tgt), 32'h003);
        check("m0_b0_btn", 32'(beats[0].btn), 32'h001);
        check("m0_b0_end", 32'(beats[0].last), 32'd0);
        check("m0_b0_idx", 32'(beats[0].idx), 32'd0);
        check("m0_b1_tgt", 32'(beats[1].tgt), 32'h003);
        check("m0_b1_btn", 32'(beats[1].btn), 32'h006);
        check("m0_b1_end", 32'(beats[1].last), 32'd1);
        check("m0_b1_idx", 32'(beats[1].idx), 32'd0);

        // Machine 1: back-pressure on the first beat
        @(posedge clk);
        #1;
        mach_in_ready = 1'b0;
        send_range(0, 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(mach_in_valid), 32'd1);
            check("stall_btn", 32'(mach_button), 32'h001);
            check("stall_tgt", 32'(mach_target), 32'h003);
            check("stall_end", 32'(mach_buttons_end), 32'd0);
            check("stall_rx_ready", 32'(rx_ready), 32'd0);
        end
        check("stall_no_beat", 32'(beats.size()), 32'd2);
        @(posedge clk);
        #1;
        mach_in_ready = 1'b1;
        send_range(5, 7);
        send_cksum();
        wait_beats(4);
        check("m1_b0_btn", 32'(beats[2].btn), 32'h001);
        check("m1_b0_idx", 32'(beats[2].idx), 32'd1);
        check("m1_b1_btn", 32'(beats[3].btn), 32'h006);
        check("m1_b1_end", 32'(beats[3].last), 32'd1);
        check("m1_b1_idx", 32'(beats[3].idx), 32'd1);

        // Machine 2: 4 lights clip both masks to 0x00F, then the run completes
        rec_q = '{8'h14, 8'hFF, 8'h03, 8'hFF, 8'hFF};
        send_range(0, 5);
        send_cksum();
        wait_beats(5);
        check("m2_tgt", 32'(beats[4].tgt), 32'h00F);
        check("m2_btn", 32'(beats[4].btn), 32'h00F);
        check("m2_end", 32'(beats[4].last), 32'd1);
        check("m2_idx", 32'(beats[4].idx), 32'd2);
        repeat (2) @(negedge clk);
        check("done_flag", 32'(parse_done), 32'd1);
        check("done_index", 32'(mach_index), 32'd2);
        rx_byte  = 8'h55;
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("done_rx_ready", 32'(rx_ready), 32'd0);
        end
        rx_valid = 1'b0;
        check("done_no_beat", 32'(beats.size()), 32'd5);

        // Malformed headers: zero/too many buttons, zero/too many lights
        bad_hdr = '{8'h0B, 8'h20, 8'hE3, 8'h1B};
        foreach (bad_hdr[i]) begin
            pulse_start();
            check("restart_fmt_clear", 32'(fmt_error), 32'd0);
            send_byte(bad_hdr[i]);
            @(negedge clk);
            check("bad_hdr_fmt", 32'(fmt_error), 32'd1);
            check("bad_hdr_rx_ready", 32'(rx_ready), 32'd1);
        end
        send_byte(8'h23);
        send_byte(8'h0B);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        check("err_no_beat", 32'(beats.size()), 32'd5);
        check("err_sticky", 32'(fmt_error), 32'd1);
        check("err_valid", 32'(mach_in_valid), 32'd0);

        // Largest legal header is accepted; parse_start then aborts it mid-record
        pulse_start();
        send_byte(8'hDA);
        send_byte(8'h01);
        @(negedge clk);
        check("max_hdr_ok", 32'(fmt_error), 32'd0);
        pulse_start();
        rec_q = '{8'h23, 8'h0B, 8'h00, 8'h01, 8'h00, 8'h06, 8'h00};
        send_range(0, 7);
        send_cksum();
        wait_beats(7);
        check("resume_b0_btn", 32'(beats[5].btn), 32'h001);
        check("resume_b0_idx", 32'(beats[5].idx), 32'd0);
        check("resume_b1_end", 32'(beats[6].last), 32'd1);

        // Asynchronous reset in the middle of a record
        pulse_start();
        send_byte(8'h23);
        send_byte(8'h0B);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rx_ready", 32'(rx_ready), 32'd0);
        check("async_target", 32'(mach_target), 32'd0);
        check("async_index", 32'(mach_index), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 32'(rx_ready), 32'd0);
        pulse_start();
        rec_q = '{8'h12, 8'h03, 8'h00, 8'h02, 8'h00};
        send_range(0, 5);
        send_cksum();
        wait_beats(8);
        check("post_rst_tgt", 32'(beats[7].tgt), 32'h003);
        check("post_rst_btn", 32'(beats[7].btn), 32'h002);
        check("post_rst_end", 32'(beats[7].last), 32'd1);
        check("post_rst_idx", 32'(beats[7].idx), 32'd0);
        repeat (5) @(negedge clk);
        check("post_rst_count", 32'(beats.size()), 32'd8);

`ifdef MRP_CHECKSUM_EN
        // Corrupted checksum byte
        pulse_start();
        send_range(0, 5);
        wait_beats(9);
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (rec_q[i]) x = x ^ rec_q[i];
            send_byte(x ^ 8'h01);
        end
        @(negedge clk);
        check("cksum_bad_fmt", 32'(fmt_error), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
